truth_sweep: RTL and testbench

Parametrised exhaustive truth-table sweeper for an N-input, 1-output combinational block under test (DUT). On `start` it drives every input combination 0..2^N−1 onto `vec` and samples the DUT output `f_in` after a programmable settle time. It assembles the observed truth table into `sig` and counts the ones. With checking compiled in, it also compares each sample against an expected table and reports mismatches. It sits beside the combinational DUT in the sample/bring-up hierarchy and replaces hand-written sequential stimulus with a synthesizable sweep engine.

---
 rtl/truth_sweep_pkg.sv | 19 +
 rtl/truth_sweep_hold.sv | 33 +++
 rtl/truth_sweep.sv | 122 ++++++++++++
 tb/tb_truth_sweep.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// truth_sweep_pkg: state encoding and configuration limits shared by the
// truth-table sweeper and its hold counter.
package truth_sweep_pkg;

  // Largest supported DUT input count and per-vector settle time.
  localparam int TS_N_MAX      = 8;
  localparam int TS_SETTLE_MAX = 15;

  // Hold counter width: wide enough to count 0..TS_SETTLE_MAX.
  localparam int TS_HOLD_W = $clog2(TS_SETTLE_MAX + 1);

  // Sweep sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_DONE = 2'd2
  } ts_state_t;

endpackage

// File: rtl/truth_sweep_hold.sv
// truth_sweep_hold: per-vector settle counter. While run is high it counts
// 0..SETTLE and raises sample for one cycle on the final hold cycle, then
// wraps so the next vector gets a full SETTLE+1 cycle hold.
module truth_sweep_hold
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic sample
);

  localparam logic [TS_HOLD_W-1:0] HOLD_LAST = TS_HOLD_W'(SETTLE);

  logic [TS_HOLD_W-1:0] cnt_reg;

  assign sample = run && (cnt_reg == HOLD_LAST);

  // Hold counter: restart on sweep start or after each sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear || sample) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= cnt_reg + TS_HOLD_W'(1);
    end
  end

endmodule

// File: rtl/truth_sweep.sv
// truth_sweep: exhaustive truth-table sweeper for an N-input, 1-output
// combinational block. Drives vec = 0..2^N-1, samples f_in after each
// SETTLE+1 cycle hold, builds sig and counts its ones.
// Optional checking against EXPECT is compiled in with TRUTH_SWEEP_CHECK_EN.
module truth_sweep
  import truth_sweep_pkg::*;
#(
  parameter int               N      = 4,
  parameter int               SETTLE = 0,
  parameter logic [(1<<N)-1:0] EXPECT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               f_in,
  output logic [N-1:0]       vec,
  output logic               busy,
  output logic               done,
  output logic [(1<<N)-1:0]  sig,
  output logic [N:0]         ones
`ifdef TRUTH_SWEEP_CHECK_EN
  ,
  output logic               pass,
  output logic [N:0]         err_count,
  output logic [N-1:0]       first_err
`endif
);

  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

  // Configuration range flag; not consumed by logic.
  wire logic unused_cfg_ok = (N >= 1) && (N <= TS_N_MAX) &&
                             (SETTLE >= 0) && (SETTLE <= TS_SETTLE_MAX);

  ts_state_t state_reg, state_next;
  logic      sample;

  wire logic start_sweep = (state_reg == TS_IDLE) && start;
  wire logic run         = (state_reg == TS_RUN);
  wire logic last_sample = sample && (vec == VEC_LAST);

  truth_sweep_hold #(.SETTLE(SETTLE)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_sweep),
    .run    (run),
    .sample (sample)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= TS_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: start only honoured in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TS_IDLE: if (start)       state_next = TS_RUN;
      TS_RUN:  if (last_sample) state_next = TS_DONE;
      TS_DONE:                  state_next = TS_IDLE;
      default:                  state_next = TS_IDLE;
    endcase
  end

  // Sweep datapath: vector stepping, truth-table capture and ones count.
  // vec stops at the last vector rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sig  <= '0;
      ones <= '0;
    end else begin
      done <= 1'b0;
      if (start_sweep) begin
        vec  <= '0;
        sig  <= '0;
        ones <= '0;
        busy <= 1'b1;
      end else if (sample) begin
        sig[vec] <= f_in;
        ones     <= ones + (N+1)'(f_in);
        if (last_sample) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          vec <= vec + N'(1);
        end
      end
    end
  end

`ifdef TRUTH_SWEEP_CHECK_EN
  wire logic mismatch = (f_in != EXPECT[vec]);

  // Checker: count mismatches, latch the lowest failing vector, and
  // resolve pass on the final sample so a last-vector miss is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass      <= 1'b0;
      err_count <= '0;
      first_err <= '0;
    end else if (start_sweep) begin
      pass      <= 1'b0;
      err_count <= '0;
      first_err <= '0;
    end else if (sample) begin
      if (mismatch) begin
        err_count <= err_count + (N+1)'(1);
        if (err_count == '0) first_err <= vec;
      end
      if (last_sample) pass <= (err_count == '0) && !mismatch;
    end
  end
`else
  wire logic unused_expect = ^EXPECT;
`endif

endmodule

// File: tb/tb_truth_sweep.sv
// tb_truth_sweep: two sweepers (SETTLE=0 and SETTLE=2) beside a behavioural
// 4-input DUT whose function is the table 16'hE8C0 (optionally stuck-at-0).
// A time-based model predicts every output each cycle; directed sequences add
// hand-computed literal checks.
module tb_truth_sweep;

  localparam logic [15:0] TBL = 16'hE8C0;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v;
  logic [1:0] stuck_v;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_tbl = TBL;

  logic [3:0]  vec0, vec2;
  logic        busy0, busy2, done0, done2;
  logic [15:0] sig0, sig2;
  logic [4:0]  ones0, ones2;
  logic        f0, f2;
  logic        pass0, pass2;
  logic [4:0]  err0, err2;
  logic [3:0]  first0, first2;

  assign f0 = stuck_v[0] ? 1'b0 : exp_tbl[vec0];
  assign f2 = stuck_v[1] ? 1'b0 : exp_tbl[vec2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_sweep #(.N(4), .SETTLE(0), .EXPECT(TBL)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .f_in(f0),
    .vec(vec0), .busy(busy0), .done(done0), .sig(sig0), .ones(ones0)
`ifdef TRUTH_SWEEP_CHECK_EN
    , .pass(pass0), .err_count(err0), .first_err(first0)
`endif
  );

  truth_sweep #(.N(4), .SETTLE(2), .EXPECT(TBL)) u2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .f_in(f2),
    .vec(vec2), .busy(busy2), .done(done2), .sig(sig2), .ones(ones2)
`ifdef TRUTH_SWEEP_CHECK_EN
    , .pass(pass2), .err_count(err2), .first_err(first2)
`endif
  );

`ifndef TRUTH_SWEEP_CHECK_EN
  assign pass0 = 1'b0;  assign err0 = '0;  assign first0 = '0;
  assign pass2 = 1'b0;  assign err2 = '0;  assign first2 = '0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is described by t = edges since the start edge: vector i is
  // sampled when t == (i+1)*(S+1); sweep ends at t == 16*(S+1).
  int          m_phase[2];   // 0 idle, 1 sweeping, 2 done cycle
  int          m_t[2];
  int          m_vec[2];
  logic [15:0] m_sig[2];
  int          m_ones[2], m_err[2], m_first[2], m_pass[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] <= 0; m_t[k] <= 0; m_vec[k] <= 0; m_sig[k] <= '0;
        m_ones[k] <= 0; m_err[k] <= 0; m_first[k] <= 0; m_pass[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int          hold  = (k == 0) ? 1 : 3;
        automatic int          ph    = m_phase[k];
        automatic int          t     = m_t[k];
        automatic int          v     = m_vec[k];
        automatic logic [15:0] sg    = m_sig[k];
        automatic int          on    = m_ones[k];
        automatic int          er    = m_err[k];
        automatic int          fe    = m_first[k];
        automatic int          ps    = m_pass[k];
        automatic int          i;
        automatic logic        b;
        if (ph == 0) begin
          if (start_v[k]) begin
            ph = 1; t = 0; v = 0; sg = '0; on = 0; er = 0; fe = 0; ps = 0;
          end
        end else if (ph == 1) begin
          t = t + 1;
          if (t % hold == 0) begin
            i = t / hold - 1;
            b = stuck_v[k] ? 1'b0 : exp_tbl[i];
            sg[i] = b;
            on = on + int'(b);
            if (b != exp_tbl[i]) begin
              if (er == 0) fe = i;
              er = er + 1;
            end
          end
          v = (t / hold > 15) ? 15 : t / hold;
          if (t == 16 * hold) begin
            ph = 2;
            ps = (er == 0) ? 1 : 0;
          end
        end else begin
          ph = 0;
        end
        m_phase[k] <= ph; m_t[k] <= t; m_vec[k] <= v; m_sig[k] <= sg;
        m_ones[k] <= on; m_err[k] <= er; m_first[k] <= fe; m_pass[k] <= ps;
      end
    end
  end

  // Compare every output of both sweepers against the model each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("u0.vec",  int'(vec0),  m_vec[0]);
      chk("u0.busy", int'(busy0), int'(m_phase[0] == 1));
      chk("u0.done", int'(done0), int'(m_phase[0] == 2));
      chk("u0.sig",  int'(sig0),  int'(m_sig[0]));
      chk("u0.ones", int'(ones0), m_ones[0]);
      chk("u2.vec",  int'(vec2),  m_vec[1]);
      chk("u2.busy", int'(busy2), int'(m_phase[1] == 1));
      chk("u2.done", int'(done2), int'(m_phase[1] == 2));
      chk("u2.sig",  int'(sig2),  int'(m_sig[1]));
      chk("u2.ones", int'(ones2), m_ones[1]);
`ifdef TRUTH_SWEEP_CHECK_EN
      chk("u0.pass", int'(pass0),  m_pass[0]);
      chk("u0.err",  int'(err0),   m_err[0]);
      chk("u0.ferr", int'(first0), m_first[0]);
      chk("u2.pass", int'(pass2),  m_pass[1]);
      chk("u2.err",  int'(err2),   m_err[1]);
      chk("u2.ferr", int'(first2), m_first[1]);
`endif
      if (done0) $display("sweep u0 done cyc=%0d sig=%h ones=%0d pass=%0d err=%0d first=%0d",
                          cyc, sig0, ones0, pass0, err0, first0);
      if (done2) $display("sweep u2 done cyc=%0d sig=%h ones=%0d pass=%0d err=%0d first=%0d",
                          cyc, sig2, ones2, pass2, err2, first2);
    end
  end

  // ---------------- directed helpers ----------------
  // Raise start at a negedge; returns the absolute number of the start edge.
  task automatic pulse_start(input int k, output int edge0);
    @(negedge clk);
    start_v[k] = 1'b1;
    edge0 = cyc + 1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int limit, output int when);
    int n;
    bit seen;
    n = 0; seen = 0; when = -1;
    while (n < limit && !seen) begin
      @(negedge clk);
      if ((k == 0) ? done0 : done2) begin
        seen = 1;
        when = cyc;
      end
      n++;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int e0, d, d_prev, n, pulses;
    rst = 1'b1; start_v = '0; stuck_v = '0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst.vec", int'(vec0), 0);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.done", int'(done0), 0);
    chk("rst.sig", int'(sig0), 0);
    chk("rst.ones", int'(ones0), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean sweep
    pulse_start(0, e0);
    wait_done(0, 40, d);
    chk("clean.done_edge", d - e0, 16);
    chk("clean.sig", int'(sig0), 32'h0000E8C0);
    chk("clean.ones", int'(ones0), 6);
`ifdef TRUTH_SWEEP_CHECK_EN
    chk("clean.pass", int'(pass0), 1);
    chk("clean.err", int'(err0), 0);
`endif
    repeat (2) @(negedge clk);

    // Stuck-at-0 DUT
    stuck_v[0] = 1'b1;
    pulse_start(0, e0);
    wait_done(0, 40, d);
    chk("stuck.sig", int'(sig0), 0);
    chk("stuck.ones", int'(ones0), 0);
`ifdef TRUTH_SWEEP_CHECK_EN
    chk("stuck.err", int'(err0), 6);
    chk("stuck.first", int'(first0), 6);
    chk("stuck.pass", int'(pass0), 0);
`endif
    @(negedge clk);
    stuck_v[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Settle timing, SETTLE=2: vec steps every 3 cycles, busy 48 cycles
    pulse_start(1, e0);
    n = 0;
    while (n < 100 && busy2) begin
      chk("settle.vec", int'(vec2), n / 3);
      n++;
      @(negedge clk);
    end
    chk("settle.busy_cycles", n, 48);
    chk("settle.done", int'(done2), 1);
    chk("settle.done_edge", cyc - e0, 48);
    repeat (3) @(negedge clk);

    // start during RUN at edge 5 is ignored
    pulse_start(0, e0);
    while (cyc < e0 + 4) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    pulses = 0; d = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done0) begin
        pulses++;
        if (d < 0) d = cyc;
      end
    end
    chk("restart.pulses", pulses, 1);
    chk("restart.done_edge", d - e0, 16);

    // Asynchronous reset mid-sweep, just after edge 7
    pulse_start(0, e0);
    while (cyc < e0 + 7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst.vec", int'(vec0), 0);
    chk("mrst.busy", int'(busy0), 0);
    chk("mrst.done", int'(done0), 0);
    chk("mrst.sig", int'(sig0), 0);
    chk("mrst.ones", int'(ones0), 0);
`ifdef TRUTH_SWEEP_CHECK_EN
    chk("mrst.pass", int'(pass0), 0);
    chk("mrst.err", int'(err0), 0);
    chk("mrst.first", int'(first0), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(0, e0);
    wait_done(0, 40, d);
    chk("mrst.resweep_sig", int'(sig0), 32'h0000E8C0);
    repeat (2) @(negedge clk);

    // Back-to-back sweeps with start held high
    @(negedge clk);
    start_v[0] = 1'b1;
    d_prev = -1;
    for (int s = 0; s < 3; s++) begin
      wait_done(0, 40, d);
      if (s > 0) chk("b2b.period", d - d_prev, 18);
      d_prev = d;
      repeat (2) @(negedge clk);
      chk("b2b.sig_cleared", int'(sig0), 0);
      chk("b2b.busy_restart", int'(busy0), 1);
    end
    start_v[0] = 1'b0;
    wait_done(0, 40, d);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
